// File: rtl/axi_burst_master.sv
// AXI4 burst master: turns one requester memory request into a single AXI read or write burst.
// Define AXI_BURST_MST_RESP_CHK_EN to flag non-OKAY RRESP/BRESP on the sticky err output.
module axi_burst_master #(
    parameter int ID_BITS   = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int MST_ID    = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    // requester side
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_BITS-1:0]     req_addr,
    input  logic [LEN_BITS-1:0]      req_len,
    input  logic [DATA_BITS-1:0]     wr_data,
    input  logic [DATA_BITS/8-1:0]   wr_strb,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     rd_valid,
    output logic                     done,
    output logic                     err,
    // AXI read address channel
    output logic [ID_BITS-1:0]       arid,
    output logic [ADDR_BITS-1:0]     araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    // AXI read data channel
    input  logic [ID_BITS-1:0]       rid,
    input  logic [DATA_BITS-1:0]     rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    // AXI write address channel
    output logic [ID_BITS-1:0]       awid,
    output logic [ADDR_BITS-1:0]     awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    // AXI write data channel
    output logic [DATA_BITS-1:0]     wdata,
    output logic [DATA_BITS/8-1:0]   wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    // AXI write response channel
    input  logic [ID_BITS-1:0]       bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam logic [2:0] AXSIZE = (DATA_BITS == 64) ? 3'd3 : 3'd2;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [LEN_BITS-1:0]    len_q, len_d;
    logic [LEN_BITS-1:0]    cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   beat_last;
    logic                   rresp_bad;
    logic                   bresp_bad;

`ifdef AXI_BURST_MST_RESP_CHK_EN
    assign rresp_bad = (rresp != 2'b00);
    assign bresp_bad = (bresp != 2'b00);
    logic unused_ok;
    assign unused_ok = ^{rid, bid};
`else
    assign rresp_bad = 1'b0;
    assign bresp_bad = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{rid, bid, rresp, bresp};
`endif

    // Counter holds the index of the current beat, so the last beat of a
    // 2^LEN_BITS burst is cnt == all-ones and no wrap is ever observed.
    assign beat_last = (cnt_q == len_q);

    assign arid    = ID_BITS'(MST_ID);
    assign awid    = ID_BITS'(MST_ID);
    assign arsize  = AXSIZE;
    assign awsize  = AXSIZE;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign done    = done_q;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = err_q;
        req_ready = 1'b0;
        arvalid   = 1'b0;
        araddr    = '0;
        arlen     = '0;
        rready    = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        awvalid   = 1'b0;
        awaddr    = '0;
        awlen     = '0;
        wvalid    = 1'b0;
        wdata     = '0;
        wstrb     = '0;
        wlast     = 1'b0;
        wr_ready  = 1'b0;
        bready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    len_d   = req_len;
                    cnt_d   = '0;
                    state_d = req_write ? S_AW : S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                araddr  = addr_q;
                arlen   = 8'(len_q);
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                rready   = 1'b1;
                rd_valid = rvalid;
                rd_data  = rdata;
                if (rvalid) begin
                    cnt_d = cnt_q + 1'b1;
                    if ((rlast != beat_last) || rresp_bad) begin
                        err_d = 1'b1;
                    end
                    if (rlast || beat_last) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                awaddr  = addr_q;
                awlen   = 8'(len_q);
                if (awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                wdata    = wr_data;
                wstrb    = wr_strb;
                wlast    = beat_last;
                if (wr_valid && wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (beat_last) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (bresp_bad) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: a hand-driven AXI slave and requester on the
// falling edge, with every expected value written out in the stimulus.
module tb_axi_burst_master;

`ifdef AXI_BURST_MST_RESP_CHK_EN
    localparam logic RESP_CHK = 1'b1;
`else
    localparam logic RESP_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, done, err;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    axi_burst_master #(
        .ID_BITS(4), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4), .MST_ID(0)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [3:0] len, input int gap,
                            input int last_beat, input logic [31:0] base, input logic exp_err);
        int beats = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
        #1 check("req_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("arvalid", arvalid, 1);
        check("araddr", araddr, addr);
        check("arlen", arlen, len);
        check("arsize", arsize, 2);
        check("arburst", arburst, 1);
        check("awvalid_in_read", awvalid, 0);
        @(negedge clk);
        #1;
        check("arvalid_hold", arvalid, 1);
        check("araddr_hold", araddr, addr);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int i = 0; i <= last_beat; i++) begin
            for (int g = 0; g < gap; g++) begin
                rvalid = 1'b0;
                #1;
                check("rd_valid_gap", rd_valid, 0);
                check("rready", rready, 1);
                @(negedge clk);
            end
            rvalid = 1'b1; rdata = base + i; rlast = (i == last_beat); rresp = 2'b00;
            #1;
            if (rd_valid) beats++;
            check("rd_data", rd_data, base + i);
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        $display("read  addr=0x%08h len=%0d beats=%0d done=%0b err=%0b", addr, len, beats, done, err);
        check("rd_beats", beats, last_beat + 1);
        check("rd_done", done, 1);
        check("rd_rready_off", rready, 0);
        check("req_ready_at_done", req_ready, 1);
        check("rd_err", err, exp_err);
        @(negedge clk);
        #1 check("rd_done_pulse", done, 0);
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [3:0] len, input logic toggle,
                             input logic [1:0] resp, input logic exp_err);
        int beats = 0;
        int lasts = 0;
        int ncyc;
        ncyc = toggle ? 2 * (len + 1) - 1 : len + 1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
        #1 check("req_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("awvalid", awvalid, 1);
        check("awaddr", awaddr, addr);
        check("awlen", awlen, len);
        check("awburst", awburst, 1);
        check("arvalid_in_write", arvalid, 0);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            wr_valid = toggle ? (c % 2 == 0) : 1'b1;
            wr_data  = 32'hB000_0000 + beats;
            wr_strb  = beats[3:0];
            #1;
            check("wvalid_pass", wvalid, wr_valid);
            check("wr_ready_pass", wr_ready, 1);
            if (wvalid && wready) begin
                check("wdata", wdata, 32'hB000_0000 + beats);
                check("wstrb", wstrb, beats[3:0]);
                check("wlast", wlast, beats == len);
                if (wlast) lasts++;
                beats++;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0; wready = 1'b0;
        #1;
        check("wr_beats", beats, len + 1);
        check("wlast_count", lasts, 1);
        check("bready", bready, 1);
        check("wvalid_in_b", wvalid, 0);
        bvalid = 1'b1; bresp = resp;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        #1;
        $display("write addr=0x%08h len=%0d beats=%0d bresp=%0d done=%0b err=%0b", addr, len, beats, resp, done, err);
        check("wr_done", done, 1);
        check("wr_err", err, exp_err);
        @(negedge clk);
        #1 check("wr_done_pulse", done, 0);
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF; wr_valid = 1'b1;
        arready = 1'b0; rid = '0; rdata = 32'h1234_5678; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b1;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wlast", wlast, 0);
        check("rst_rready", rready, 0);
        check("rst_bready", bready, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_araddr", araddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wstrb", wstrb, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rstn = 1'b1; wr_valid = 1'b0; rvalid = 1'b0;

        read_txn(32'h0001_0000, 4'd0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        read_txn(32'h0002_0000, 4'd3, 2, 3, 32'h1111_0000, 1'b0);
        write_txn(32'h0003_0000, 4'd15, 1'b1, 2'b00, 1'b0);
        write_txn(32'h0003_1000, 4'd0, 1'b0, 2'b10, RESP_CHK);

        @(negedge clk);
        rstn = 1'b0;
        #1 check("err_cleared_by_reset", err, 0);
        @(negedge clk);
        rstn = 1'b1;

        // RLAST arrives on beat 2 of a 4-beat read; err must stick afterwards
        read_txn(32'h0005_0000, 4'd3, 0, 1, 32'h2222_0000, 1'b1);
        read_txn(32'h0005_1000, 4'd0, 0, 0, 32'h3333_0000, 1'b1);

        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // reset asserted during beat 2 of a 4-beat read
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0006_0000; req_len = 4'd3;
        @(negedge clk);
        req_valid = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0055; rlast = 1'b0;
        #1 check("midrst_beat1", rd_valid, 1);
        @(negedge clk);
        rdata = 32'h0000_0056;
        #1 check("midrst_rready_before", rready, 1);
        rstn = 1'b0;
        #1;
        $display("midrst rready=%0b req_ready=%0b rd_valid=%0b", rready, req_ready, rd_valid);
        check("midrst_rready", rready, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rvalid = 1'b0; rstn = 1'b1;
        read_txn(32'h0007_0000, 4'd0, 0, 0, 32'hCAFE_F00D, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Parametrised AXI4 master port that turns one requester-side memory request into a single AXI read or write burst. It is the successor to the fixed single-beat instruction/data master ports in the CPU wrapper. It adds:
- configurable data, address, ID and length widths;
- bursts of 1 to 2^LEN_BITS beats with beat counting and WLAST generation;
- RLAST consistency checking;
- optional error-response capture.

One instance sits between a requester (CPU fetch unit, cache line-fill engine, DMA) and one master port of the AXI bus.

## Interface
Parameters:
- ID_BITS, 4, AXI ID width
- ADDR_BITS, 32, address width
- DATA_BITS, 32, data width; must be 32 or 64; STRB_BITS = DATA_BITS/8
- LEN_BITS, 4, burst length field width; max burst is 2^LEN_BITS beats
- MST_ID, 0, constant driven on ARID/AWID

Ports:
- clk  in  1  clock; all logic on its rising edge
- rstn  in  1  reset, asynchronous and active-low; one clock, no other reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_BITS  start address, aligned to DATA_BITS/8
- req_len  in  LEN_BITS  beats minus 1
- wr_data  in  DATA_BITS  write beat data
- wr_strb  in  STRB_BITS  write beat strobes
- wr_valid  in  1  write beat available
- wr_ready  out  1  write beat consumed when high with wr_valid
- rd_data  out  DATA_BITS  read beat data; valid only with rd_valid
- rd_valid  out  1  read beat strobe; the requester cannot stall it
- done  out  1  one-cycle pulse at transaction completion
- err  out  1  sticky error flag; cleared only by reset
- AR*, R*, AW*, W*, B* channel ports  AXI4 master side, widths per parameters
  - ARSIZE/AWSIZE = log2(DATA_BITS/8)
  - ARBURST/AWBURST = INCR

## Operation
States:
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr, len and write; clear beat counter; go to AR if read, AW if write.
- AR: ARVALID = 1 with latched addr/len; on ARREADY go to R.
- R:
  - RREADY = 1; rd_data = RDATA and rd_valid = RVALID.
  - Each handshake increments the beat counter.
  - Transaction ends on the handshake where RLAST = 1 or counter = len; then pulse done and go to IDLE.
  - If RLAST and counter disagree, set err; completion still happens on RLAST.
- AW: AWVALID = 1; on AWREADY go to W.
- W:
  - WVALID = wr_valid, wr_ready = WREADY, WDATA/WSTRB pass through.
  - WLAST = (counter == len).
  - Counter increments on each W handshake; after the last beat go to B.
- B: BREADY = 1; on BVALID pulse done and go to IDLE.

Rules:
- AR and AW are never asserted together; only one transaction is ever outstanding.
- Once asserted, ARVALID and AWVALID hold with stable payload until handshake.
- The beat counter is LEN_BITS wide. len = all-ones means 2^LEN_BITS beats, and the counter must not wrap before WLAST.
- RID/BID are ignored; the single-outstanding rule makes them unnecessary.

## Timing
- Reset values:
  - state IDLE; req_ready 1.
  - ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY, wr_ready, rd_valid, done, err all 0.
  - Address, data and strobe outputs 0.
- Address valid rises the cycle after request acceptance; there is no combinational path from req_valid to ARVALID/AWVALID.
- rd_data and rd_valid are combinational from R, so beat latency is 0 cycles.
- done is asserted in the cycle after the final handshake; a new request can be accepted in that same cycle.
- Minimum single-beat read is 3 cycles from req accept to done, with a zero-wait slave.
- rstn asserted mid-burst: immediate return to IDLE and all outputs at reset values. The requester must discard any partial transfer.

## Configuration
- AXI_BURST_MST_RESP_CHK_EN defined:
  - any RRESP or BRESP other than OKAY sets err;
  - that response's done pulse still occurs.
- AXI_BURST_MST_RESP_CHK_EN undefined:
  - RRESP and BRESP are ignored;
  - err reflects only RLAST/count mismatch.

## Test plan
- Single read:
  - stimulus: addr 0x0001_0000, len 0, slave returns 0xDEADBEEF with RLAST;
  - required: ARLEN 0, one rd_valid with 0xDEADBEEF, done 1 cycle later, err 0.
- Burst read:
  - stimulus: len 3, slave inserts 2-cycle RVALID gaps;
  - required: exactly 4 rd_valid pulses in order, done after 4th beat.
- Burst write:
  - stimulus: len 15 (LEN_BITS=4), wr_valid toggling every other cycle;
  - required: 16 W handshakes, WLAST only on the 16th, BREADY then done.
- RLAST mismatch:
  - stimulus: len 3, slave asserts RLAST on beat 2;
  - required: done after beat 2, err 1 and stays 1.
- SLVERR write with macro defined:
  - stimulus: BRESP = 2'b10;
  - required: done pulses, err 1; with macro undefined err stays 0.
- Mid-burst reset:
  - stimulus: rstn low during R beat 2 of 4;
  - required: RREADY 0 and req_ready 1 in the same cycle; the next request proceeds normally.
